// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// an optional one-entry skid buffer, synchronous flush and a Tnew hazard
// countdown applied on capture. The payload is opaque; only the register-file
// write fields and Tnew are interpreted, to produce the forwarding flag used
// by the hazard unit.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int TNEW_W = 2,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic              in_regwrite,
    input  logic [4:0]        in_wa,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TNEW_W-1:0] out_tnew,
    output logic              out_regwrite,
    output logic [4:0]        out_wa,
    output logic              out_fwd
);

    // One held pipeline entry.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TNEW_W-1:0] tnew;
        logic              regwrite;
        logic [4:0]        wa;
    } entry_t;

    // Occupancy of the stage. TWO is only reachable when the skid buffer exists.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e   state_q;
    occ_e   state_d;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;

    logic   in_xfer;
    logic   out_xfer;
    logic   load_main;
    logic   load_skid;
    logic   main_from_skid;

    // Handshake decode. With the skid buffer, in_ready comes from the state
    // register alone so no ready path runs combinationally through the stage.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = SKID ? (state_q != TWO) : (~out_valid | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Build the entry to capture: Tnew counts down by one on entering this
    // stage and saturates at zero; it does not count further while held.
    always_comb begin
        in_entry          = '0;
        in_entry.data     = in_data;
        in_entry.tnew     = (in_tnew == '0) ? '0 : (in_tnew - TNEW_W'(1));
        in_entry.regwrite = in_regwrite;
        in_entry.wa       = in_wa;
    end

    // Next occupancy and datapath load selects; flush kills everything held
    // and suppresses any same-cycle capture.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer && SKID) begin
                        load_skid = 1'b1;
                        state_d   = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Occupancy register; reset dominates flush, which dominates transfers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry storage: main is the head, skid only ever refills main, so the
    // younger entry can never overtake the older one.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the payload registers are reset too, so every out_* field
            // reads zero right after reset rather than leftover data.
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_entry;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Head outputs. The write enable is gated by out_valid so a bubble or a
    // flushed slot never looks like a register write; out_fwd depends only
    // on registered state.
    assign out_data     = main_q.data;
    assign out_tnew     = main_q.tnew;
    assign out_wa       = main_q.wa;
    assign out_regwrite = out_valid & main_q.regwrite;
    assign out_fwd      = out_regwrite & (main_q.wa != 5'd0) & (main_q.tnew == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: one instance with the skid
// buffer, one without.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          reset;

    // Skid instance signals.
    logic          flush, in_valid, in_ready, in_regwrite;
    logic [DW-1:0] in_data;
    logic [TW-1:0] in_tnew;
    logic [4:0]    in_wa;
    logic          out_valid, out_ready, out_regwrite, out_fwd;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tnew;
    logic [4:0]    out_wa;

    // Single-entry instance signals.
    logic          flush0, in_valid0, in_ready0, in_regwrite0;
    logic [DW-1:0] in_data0;
    logic [TW-1:0] in_tnew0;
    logic [4:0]    in_wa0;
    logic          out_valid0, out_ready0, out_regwrite0, out_fwd0;
    logic [DW-1:0] out_data0;
    logic [TW-1:0] out_tnew0;
    logic [4:0]    out_wa0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .TNEW_W(TW), .SKID(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tnew(in_tnew), .in_regwrite(in_regwrite), .in_wa(in_wa),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tnew(out_tnew), .out_regwrite(out_regwrite), .out_wa(out_wa),
        .out_fwd(out_fwd)
    );

    pipe_stage_reg #(.DATA_W(DW), .TNEW_W(TW), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .in_tnew(in_tnew0), .in_regwrite(in_regwrite0), .in_wa(in_wa0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_tnew(out_tnew0), .out_regwrite(out_regwrite0), .out_wa(out_wa0),
        .out_fwd(out_fwd0)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one entry to the skid instance and clock it in.
    task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t,
                        input logic rw, input logic [4:0] wa);
        in_valid    = 1'b1;
        in_data     = d;
        in_tnew     = t;
        in_regwrite = rw;
        in_wa       = wa;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_out_valid"},    out_valid,    1'b0);
        check({pfx, "_out_data"},     out_data,     '0);
        check({pfx, "_out_tnew"},     out_tnew,     '0);
        check({pfx, "_out_regwrite"}, out_regwrite, 1'b0);
        check({pfx, "_out_wa"},       out_wa,       5'd0);
        check({pfx, "_out_fwd"},      out_fwd,      1'b0);
        check({pfx, "_in_ready"},     in_ready,     1'b1);
    endtask

    logic [TW-1:0] tn_in  [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [TW-1:0] tn_exp [4] = '{2'd1, 2'd0, 2'd0, 2'd2};
    logic          fwd_exp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic          rdy_pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_tnew = '0;
        in_regwrite = 1'b0; in_wa = '0; out_ready = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; in_tnew0 = '0;
        in_regwrite0 = 1'b0; in_wa0 = '0; out_ready0 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("rst");
        check("rst_s0_out_valid", out_valid0, 1'b0);
        check("rst_s0_in_ready",  in_ready0,  1'b1);

        // Reset then stream at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stream_in_ready", in_ready, 1'b1);
            send(DW'(32'h100 + i), tn_in[i], 1'b1, 5'd5);
            check("stream_out_valid", out_valid, 1'b1);
            check("stream_out_data",  out_data,  DW'(32'h100 + i));
            check("stream_out_tnew",  out_tnew,  tn_exp[i]);
            check("stream_out_fwd",   out_fwd,   fwd_exp[i]);
            check("stream_out_wa",    out_wa,    5'd5);
        end
        tick();
        check("bubble_out_valid",    out_valid,    1'b0);
        check("bubble_out_regwrite", out_regwrite, 1'b0);
        check("bubble_out_fwd",      out_fwd,      1'b0);

        // Backpressure fill into the skid, then drain in order.
        out_ready = 1'b0;
        send(DW'(32'hA), 2'd0, 1'b1, 5'd7);
        check("bp_in_ready_one", in_ready, 1'b1);
        send(DW'(32'hB), 2'd0, 1'b1, 5'd8);
        check("bp_in_ready_two", in_ready, 1'b0);
        check("bp_head_a",       out_data, DW'(32'hA));
        tick();
        check("bp_head_a_held",  out_data, DW'(32'hA));
        check("bp_wa_a_held",    out_wa,   5'd7);
        out_ready = 1'b1;
        tick();
        check("bp_head_b",       out_data,  DW'(32'hB));
        check("bp_head_b_wa",    out_wa,    5'd8);
        check("bp_head_b_valid", out_valid, 1'b1);
        check("bp_in_ready_back", in_ready, 1'b1);
        tick();
        check("bp_drained", out_valid, 1'b0);

        // Flush in TWO with an incoming entry.
        out_ready = 1'b0;
        send(DW'(32'hA1), 2'd0, 1'b1, 5'd1);
        send(DW'(32'hB1), 2'd0, 1'b1, 5'd2);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(32'hC1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush2_out_valid", out_valid, 1'b0);
        check("flush2_in_ready",  in_ready,  1'b1);
        check("flush2_fwd",       out_fwd,   1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush2_no_c", out_valid, 1'b0);

        // Flush in ONE while an in-transfer would otherwise be accepted.
        out_ready = 1'b0;
        send(DW'(32'hA2), 2'd0, 1'b1, 5'd1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(32'hC2);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1_out_valid", out_valid, 1'b0);
        tick();
        check("flush1_no_c", out_valid, 1'b0);

        // Reset, flush and transfers all in the same cycle.
        out_ready = 1'b0;
        send(DW'(32'h77), 2'd0, 1'b1, 5'd3);
        check("pre_rst_fwd", out_fwd, 1'b1);
        reset = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = DW'(32'h99);
        in_regwrite = 1'b1;
        in_wa = 5'd9;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        check_reset_values("rstmix");
        send(DW'(32'h5A), 2'd0, 1'b0, 5'd0);
        check("d_out_valid", out_valid, 1'b1);
        check("d_out_data",  out_data,  DW'(32'h5A));
        tick();
        check("d_drained", out_valid, 1'b0);

        // Zero-register guard.
        out_ready = 1'b0;
        send(DW'(32'h33), 2'd0, 1'b1, 5'd0);
        check("zero_out_valid",    out_valid,    1'b1);
        check("zero_out_regwrite", out_regwrite, 1'b1);
        check("zero_out_fwd",      out_fwd,      1'b0);
        out_ready = 1'b1;
        tick();
        check("zero_drained", out_valid, 1'b0);

        // Single-entry instance with toggling downstream ready.
        begin
            logic m_valid;
            logic exp_rdy;
            int   seq;
            int   rx;
            m_valid = 1'b0;
            seq = 0;
            rx = 0;
            for (int i = 0; i < 8; i++) begin
                out_ready0 = rdy_pat[i];
                in_valid0  = (i < 6);
                in_data0   = DW'(seq);
                #1;
                exp_rdy = !m_valid || out_ready0;
                check("s0_in_ready",  in_ready0,  exp_rdy);
                check("s0_out_valid", out_valid0, m_valid);
                if (m_valid && out_ready0) begin
                    check("s0_seq", out_data0, DW'(rx));
                    rx++;
                end
                if (in_valid0 && exp_rdy) begin
                    m_valid = 1'b1;
                    seq++;
                end else if (m_valid && out_ready0) begin
                    m_valid = 1'b0;
                end
                tick();
            end
            in_valid0 = 1'b0;
            check("s0_count",   rx, 4);
            check("s0_drained", out_valid0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
